// File: rtl/binary_mul_pkg.sv
// Shared constants and state encoding for the 8x8 signed serial multiplier
// and the sequencer that feeds it.
package binary_mul_pkg;

  localparam int MUL_LATENCY = 9;   // posedges from operand change to valid P
  localparam int OPER_W      = 8;   // signed operand width
  localparam int MUL_W       = 15;  // signed product width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/binary_dot_seq_if.sv
// Operand, multiplier and result signals of binary_dot_seq.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. The producer holds data stable while valid is high and
// ready is low; valid does not depend on ready. The sequencer never raises
// in_ready and out_valid together.
interface binary_dot_seq_if #(
  parameter int ACC_W = 24
);
  import binary_mul_pkg::*;

  // operand side
  logic              in_valid;
  logic              in_ready;
  logic [OPER_W-1:0] in_a;
  logic [OPER_W-1:0] in_b;
  logic              in_last;

  // multiplier side
  logic [OPER_W-1:0] mul_a;
  logic [OPER_W-1:0] mul_b;
  logic              mul_en;
  logic [MUL_W-1:0]  mul_p;

  // result side
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;

  // environment: operand producer, multiplier and result consumer
  modport master (
    output in_valid, in_a, in_b, in_last, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, mul_en, out_valid, out_data, out_ovf
  );

  // the sequencer itself
  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_p, out_ready,
    output in_ready, mul_a, mul_b, mul_en, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/binary_dot_acc.sv
// Sign-extending dot-product accumulator with sticky signed-overflow flag.
// sum_next/ovf_next show the result of the pending add so the caller can
// capture the final sum on the same edge that commits it.
module binary_dot_acc
  import binary_mul_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    add_en,
  input  logic                    clr,
  input  logic signed [MUL_W-1:0] p,
  output logic signed [ACC_W-1:0] sum_next,
  output logic                    ovf_next
);

  logic signed [ACC_W-1:0] acc;
  logic                    ovf;
  logic signed [ACC_W-1:0] p_ext;
  logic                    add_ovf;

  assign p_ext    = ACC_W'(p);
  assign sum_next = acc + p_ext;
  // Signed overflow: both addends share a sign and the wrapped sum does not.
  assign add_ovf  = (acc[ACC_W-1] == p_ext[ACC_W-1]) &&
                    (sum_next[ACC_W-1] != acc[ACC_W-1]);
  assign ovf_next = ovf | add_ovf;

  // Accumulate sampled products; clear wins when a result is handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= sum_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: rtl/binary_dot_seq.sv
// Issue/accumulate sequencer around the fixed-latency 8x8 signed multiplier.
// Each accepted pair is held on the multiplier inputs for LATENCY edges; the
// product is then folded into the running sum. The pair flagged last
// publishes the sum and overflow flag over the result handshake.
module binary_dot_seq
  import binary_mul_pkg::*;
#(
  parameter  int LATENCY = MUL_LATENCY,
  parameter  int ACC_W   = 24,
  localparam int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  binary_dot_seq_if.slave  bus,
  output seq_state_t       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              last_q;
  logic              in_ready_q;
  logic [OPER_W-1:0] mul_a_q;
  logic [OPER_W-1:0] mul_b_q;
  logic              mul_en_q;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_data_q;
  logic              out_ovf_q;

  logic                    add_en;
  logic                    clr;
  logic signed [ACC_W-1:0] sum_next;
  logic                    ovf_next;

  // Product is sampled on the edge where the counter reaches LATENCY.
  assign add_en = (state == S_WAIT) && (cnt == CNT_W'(LATENCY));
  // The accumulator restarts once the consumer takes the result.
  assign clr    = (state == S_OUT) && bus.out_ready;

  binary_dot_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .add_en   (add_en),
    .clr      (clr),
    .p        (bus.mul_p),
    .sum_next (sum_next),
    .ovf_next (ovf_next)
  );

  // Sequencer FSM: accept a pair, wait out the multiplier, publish on last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            mul_a_q    <= bus.in_a;
            mul_b_q    <= bus.in_b;
            last_q     <= bus.in_last;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            mul_en_q   <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == CNT_W'(LATENCY)) begin
            // Counter parks at zero so it never runs past LATENCY.
            cnt      <= '0;
            mul_en_q <= 1'b0;
            if (last_q) begin
              out_data_q  <= sum_next;
              out_ovf_q   <= ovf_next;
              out_valid_q <= 1'b1;
              state       <= S_OUT;
            end else begin
              in_ready_q <= 1'b1;
              state      <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_en    = mul_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign dbg_state     = state;
  assign dbg_cnt       = cnt;

endmodule

// File: tb/tb_binary_dot_seq.sv
// Bench for binary_dot_seq: two instances (24-bit and 16-bit accumulators)
// share one stimulus stream, each with its own behavioural multiplier.
module tb_binary_dot_seq;
  import binary_mul_pkg::*;

  localparam int LAT = MUL_LATENCY;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  binary_dot_seq_if #(.ACC_W(24)) b24 ();
  binary_dot_seq_if #(.ACC_W(16)) b16 ();
  seq_state_t st24, st16;
  logic [3:0] cnt24, cnt16;

  binary_dot_seq #(.LATENCY(LAT), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .bus(b24), .dbg_state(st24), .dbg_cnt(cnt24));
  binary_dot_seq #(.LATENCY(LAT), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .bus(b16), .dbg_state(st16), .dbg_cnt(cnt16));

  logic       in_valid = 1'b0;
  logic       in_last  = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;

  assign b24.in_valid = in_valid;  assign b16.in_valid = in_valid;
  assign b24.in_a = in_a;          assign b16.in_a = in_a;
  assign b24.in_b = in_b;          assign b16.in_b = in_b;
  assign b24.in_last = in_last;    assign b16.in_last = in_last;
  assign b24.out_ready = out_ready; assign b16.out_ready = out_ready;

  // Behavioural multiplier: P shows a*b exactly LAT edges after the operands change.
  logic [14:0] pipe24 [LAT];
  logic [14:0] pipe16 [LAT];
  logic signed [15:0] prod24, prod16;
  assign prod24 = $signed(b24.mul_a) * $signed(b24.mul_b);
  assign prod16 = $signed(b16.mul_a) * $signed(b16.mul_b);
  always @(posedge clk) begin
    pipe24[0] <= prod24[14:0];
    pipe16[0] <= prod16[14:0];
    for (int i = 1; i < LAT; i++) begin
      pipe24[i] <= pipe24[i-1];
      pipe16[i] <= pipe16[i-1];
    end
  end
  assign b24.mul_p = pipe24[LAT-1];
  assign b16.mul_p = pipe16[LAT-1];

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [41:0] exp_q[$];   // {ovf16, data16, ovf24, data24}
  longint acc24_m = 0, acc16_m = 0;
  bit     ovf24_m = 0, ovf16_m = 0;
  logic [7:0]  exp_a = '0, exp_b = '0;
  int unsigned last_acc_cyc = 0;
  int     rmode = 0;   // 0: out_ready high, 1: low, 2: random

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Exact sum into a w-bit signed register: flag whenever the true sum leaves range.
  task automatic model_add(input longint p, input int w, inout longint acc, inout bit ovf);
    longint s;
    longint lim;
    s   = acc + p;
    lim = longint'(1) << (w - 1);
    if (s >= lim || s < -lim) ovf = 1'b1;
    acc = wrap(s, w);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge. Waits for in_ready, presents the pair, returns at the
  // negedge after the accepting edge. With noise, inputs toggle randomly
  // while in_ready is low.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last,
                      input bit noise, input bit hold);
    int n;
    longint p;
    n = 0;
    while (!b24.in_ready) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_last = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
      if (n > 300) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    exp_a = a; exp_b = b;
    last_acc_cyc = cyc + 1;
    p = longint'($signed(a)) * longint'($signed(b));
    model_add(p, 24, acc24_m, ovf24_m);
    model_add(p, 16, acc16_m, ovf16_m);
    if (last) begin
      exp_q.push_back({ovf16_m, acc16_m[15:0], ovf24_m, acc24_m[23:0]});
      acc24_m = 0; acc16_m = 0; ovf24_m = 0; ovf16_m = 0;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || b24.out_valid || !b24.in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("result_timeout", 0, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", b24.in_ready, 1);
    check("rst_mul_a", b24.mul_a, 0);
    check("rst_mul_b", b24.mul_b, 0);
    check("rst_mul_en", b24.mul_en, 0);
    check("rst_out_valid", b24.out_valid, 0);
    check("rst_out_data", b24.out_data, 0);
    check("rst_out_ovf", b24.out_ovf, 0);
    check("rst_state", int'(st24), int'(S_IDLE));
    check("rst_cnt", cnt24, 0);
    check("rst16_out_data", b16.out_data, 0);
    check("rst16_out_valid", b16.out_valid, 0);
    check("rst16_in_ready", b16.in_ready, 1);
  endtask

  // out_ready changes just after the active edge
  always begin
    @(posedge clk);
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- monitor ----------------
  logic        prev_ov = 1'b0;
  logic        prev_hs = 1'b0;
  logic [23:0] hold24 = '0;
  logic [15:0] hold16 = '0;
  logic [41:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      n_tests++;
      if (cnt24 > 4'(LAT) || cnt16 > 4'(LAT)) begin
        n_fail++;
        $display("FAIL cnt_max: got %0d/%0d limit %0d", cnt24, cnt16, LAT);
      end
      if (st24 == S_WAIT) begin
        check("wait_mul_a", b24.mul_a, exp_a);
        check("wait_mul_b", b24.mul_b, exp_b);
        check("wait_mul_en", b24.mul_en, 1);
        check("wait16_mul_a", b16.mul_a, exp_a);
        check("wait16_mul_b", b16.mul_b, exp_b);
      end
      if (b24.out_valid && !prev_ov) begin
        check("out_latency", longint'(cyc) - longint'(last_acc_cyc), LAT + 1);
        check("out16_valid", b16.out_valid, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data24", $signed(b24.out_data), $signed(e[23:0]));
          check("out_ovf24", b24.out_ovf, e[24]);
          check("out_data16", $signed(b16.out_data), $signed(e[40:25]));
          check("out_ovf16", b16.out_ovf, e[41]);
        end
        hold24 = b24.out_data;
        hold16 = b16.out_data;
      end else if (b24.out_valid) begin
        check("stall_data24", b24.out_data, hold24);
        check("stall_data16", b16.out_data, hold16);
      end
      if (b24.out_valid) check("ready_during_out", b24.in_ready, 0);
      if (prev_hs) begin
        check("post_hs_in_ready", b24.in_ready, 1);
        check("post_hs_out_valid", b24.out_valid, 0);
      end
      prev_hs = b24.out_valid && out_ready;
      prev_ov = b24.out_valid;
    end
  end

  // ---------------- stimulus ----------------
  int unsigned acc_cyc [6];
  logic [7:0]  ra, rb;
  int          len, n;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // small mixed-sign vector: 12 - 30 - 56 = -74
    send(8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
    send(8'(-5), 8'd6, 1'b0, 1'b0, 1'b0);
    send(8'd7, 8'(-8), 1'b1, 1'b0, 1'b0);
    wait_out();

    // single pair at the operand extremes
    send(8'h80, 8'd127, 1'b1, 1'b0, 1'b0);
    wait_out();

    // 16-bit sum overflows on the third pair; next vector starts clean
    repeat (2) send(8'd127, 8'd127, 1'b0, 1'b0, 1'b0);
    send(8'd127, 8'd127, 1'b1, 1'b0, 1'b0);
    send(8'd1, 8'd1, 1'b1, 1'b0, 1'b0);
    wait_out();

    // consumer stall
    rmode = 1;
    send(8'd5, 8'(-9), 1'b0, 1'b0, 1'b0);
    send(8'(-3), 8'd11, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!b24.out_valid && n < 100) begin @(negedge clk); n++; end
    check("stall_reached_out", b24.out_valid, 1);
    repeat (20) @(negedge clk);
    check("stall_out_valid", b24.out_valid, 1);
    check("stall_in_ready", b24.in_ready, 0);
    rmode = 0;
    wait_out();

    // reset mid-WAIT on the second pair discards the partial vector
    send(8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
    send(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals();
    acc24_m = 0; acc16_m = 0; ovf24_m = 0; ovf16_m = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    send(8'd2, 8'd2, 1'b1, 1'b0, 1'b0);
    wait_out();

    // in_valid held high: one accept every LAT+2 edges
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (ra == 8'h80 && rb == 8'h80) rb = 8'h81;
      send(ra, rb, (i == 5), 1'b0, 1'b1);
      acc_cyc[i] = last_acc_cyc;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 6; i++)
      check("btb_spacing", longint'(acc_cyc[i]) - longint'(acc_cyc[i-1]), LAT + 2);
    wait_out();

    // random vectors, random consumer stalls, input noise while busy
    rmode = 2;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if (ra == 8'h80 && rb == 8'h80) rb = 8'h81;
        send(ra, rb, (k == len - 1), 1'($urandom_range(0, 1)), 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    rmode = 0;
    wait_out();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
